// File: rtl/issue_queue_pkg.sv
// Shared widths, entry layout and pop-count helper for the instruction issue queue.
package issue_queue_pkg;

    localparam int unsigned IqDepth     = 16;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned BpuBus      = 33;

    typedef struct packed {
        logic [InstBus-1:0]     inst;
        logic [InstAddrBus-1:0] pc;
        logic [BpuBus-1:0]      bpu;
    } iq_entry_t;

    localparam int unsigned EntryW = $bits(iq_entry_t);

    // Number of entries leaving the queue this cycle (0, 1 or 2).
    function automatic logic [1:0] pop_num(input logic issued, input logic dual,
                                           input logic has1, input logic has2);
        logic [1:0] n;
        n = 2'd0;
        if (issued && has1) begin
            n = (dual && has2) ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_ram.sv
// Entry storage: DEPTH x EntryW, two write ports, two asynchronous read ports, no reset.
module iq_ram
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IqDepth,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we1,
    input  logic [AW-1:0]     i_waddr1,
    input  logic [EntryW-1:0] i_wdata1,
    input  logic              i_we2,
    input  logic [AW-1:0]     i_waddr2,
    input  logic [EntryW-1:0] i_wdata2,
    input  logic [AW-1:0]     i_raddr1,
    output logic [EntryW-1:0] o_rdata1,
    input  logic [AW-1:0]     i_raddr2,
    output logic [EntryW-1:0] o_rdata2
);

    logic [EntryW-1:0] r_mem [DEPTH];

    // Write addresses are always tail and tail+1, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
        if (i_we2) begin
            r_mem[i_waddr2] <= i_wdata2;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/issue_queue.sv
// Dual-lane instruction queue between fetch and decode with delay-slot tracking and flush.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IqDepth,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push1_i,
    input  logic                   push2_i,
    input  logic [InstBus-1:0]     push_inst1_i,
    input  logic [InstBus-1:0]     push_inst2_i,
    input  logic [InstAddrBus-1:0] push_pc1_i,
    input  logic [InstAddrBus-1:0] push_pc2_i,
    input  logic [BpuBus-1:0]      push_bpu1_i,
    input  logic [BpuBus-1:0]      push_bpu2_i,
    output logic                   full_o,
    output logic [InstBus-1:0]     inst1_o,
    output logic [InstBus-1:0]     inst2_o,
    output logic [InstAddrBus-1:0] pc1_o,
    output logic [InstAddrBus-1:0] pc2_o,
    output logic [BpuBus-1:0]      bpu_o,
    output logic                   issue_en_o,
    input  logic                   issued_i,
    input  logic                   dual_i,
    input  logic                   ninst_in_delayslot_i,
    output logic                   is_in_delayslot_o,
    output logic [CW-1:0]          count_o
);

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_dly;

    logic          w_full;
    logic          w_has1;
    logic          w_has2;
    logic          w_we1;
    logic          w_we2;
    logic [1:0]    w_npush;
    logic [1:0]    w_npop;
    logic [AW-1:0] w_head_p1;
    logic [AW-1:0] w_tail_p1;
    iq_entry_t     w_wd1;
    iq_entry_t     w_wd2;
    iq_entry_t     w_rd1;
    iq_entry_t     w_rd2;
    logic          w_unused_bpu2;

    assign w_full    = r_count > CW'(DEPTH - 2);
    assign w_has1    = r_count != '0;
    assign w_has2    = r_count >= CW'(2);
    assign w_head_p1 = r_head + AW'(1);
    assign w_tail_p1 = r_tail + AW'(1);

    // A lane-2 push without lane 1 would leave a hole, so lane 2 is gated by lane 1.
    assign w_we1   = push1_i && !w_full;
    assign w_we2   = w_we1 && push2_i;
    assign w_npush = {1'b0, w_we1} + {1'b0, w_we2};
    assign w_npop  = pop_num(issued_i, dual_i, w_has1, w_has2);

    assign w_wd1 = '{inst: push_inst1_i, pc: push_pc1_i, bpu: push_bpu1_i};
    assign w_wd2 = '{inst: push_inst2_i, pc: push_pc2_i, bpu: push_bpu2_i};

    iq_ram #(
        .DEPTH (DEPTH)
    ) u_iq_ram (
        .clk      (clk),
        .i_we1    (w_we1),
        .i_waddr1 (r_tail),
        .i_wdata1 (w_wd1),
        .i_we2    (w_we2),
        .i_waddr2 (w_tail_p1),
        .i_wdata2 (w_wd2),
        .i_raddr1 (r_head),
        .o_rdata1 (w_rd1),
        .i_raddr2 (w_head_p1),
        .o_rdata2 (w_rd2)
    );

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_dly   <= 1'b0;
        end else begin
            r_head  <= r_head + AW'(w_npop);
            r_tail  <= r_tail + AW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_npop);
            if (issued_i && !dual_i && ninst_in_delayslot_i) begin
                r_dly <= 1'b1;
            end else if (w_npop != 2'd0) begin
                r_dly <= 1'b0;
            end
        end
    end

    // Storage is never reset, so empty slots are masked to zero (decodes as NOP).
    always_comb begin
        inst1_o = '0;
        pc1_o   = '0;
        bpu_o   = '0;
        inst2_o = '0;
        pc2_o   = '0;
        if (w_has1) begin
            inst1_o = w_rd1.inst;
            pc1_o   = w_rd1.pc;
            bpu_o   = w_rd1.bpu;
        end
        if (w_has2) begin
            inst2_o = w_rd2.inst;
            pc2_o   = w_rd2.pc;
        end
    end

    assign w_unused_bpu2     = ^w_rd2.bpu;
    assign full_o            = w_full;
    assign issue_en_o        = w_has1;
    assign is_in_delayslot_o = r_dly;
    assign count_o           = r_count;

endmodule
